// File: rtl/cpu_exec_ctrl.sv
// Execute/sequencing core of the single-cycle CPU: control decoder, ALU with
// operand-B select, Ra==Rb comparator, PC adder and PC register.
module cpu_exec_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [3:0]  LINK_REG = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [31:0] ra_data,
    input  logic [31:0] rb_data,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_out,
    output logic        eq,
    output logic        m1,
    output logic        m2,
    output logic        m3,
    output logic        m4,
    output logic        m5,
    output logic        m6,
    output logic        m7,
    output logic        wr_en
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;

    // Instruction opcodes
    localparam logic [OPW-1:0] OP_ADD  = 4'h0;
    localparam logic [OPW-1:0] OP_SUB  = 4'h1;
    localparam logic [OPW-1:0] OP_AND  = 4'h2;
    localparam logic [OPW-1:0] OP_OR   = 4'h3;
    localparam logic [OPW-1:0] OP_XOR  = 4'h4;
    localparam logic [OPW-1:0] OP_SLL  = 4'h5;
    localparam logic [OPW-1:0] OP_SRL  = 4'h6;
    localparam logic [OPW-1:0] OP_SLT  = 4'h7;
    localparam logic [OPW-1:0] OP_ADDI = 4'h8;
    localparam logic [OPW-1:0] OP_ANDI = 4'h9;
    localparam logic [OPW-1:0] OP_ORI  = 4'hA;
    localparam logic [OPW-1:0] OP_LUI  = 4'hB;
    localparam logic [OPW-1:0] OP_MOV  = 4'hC;
    localparam logic [OPW-1:0] OP_BEQ  = 4'hD;
    localparam logic [OPW-1:0] OP_JR   = 4'hE;
    localparam logic [OPW-1:0] OP_BNE  = 4'hF;

    // ALU operation codes
    localparam logic [OPW-1:0] ALU_ADD  = 4'h0;
    localparam logic [OPW-1:0] ALU_SUB  = 4'h1;
    localparam logic [OPW-1:0] ALU_AND  = 4'h2;
    localparam logic [OPW-1:0] ALU_OR   = 4'h3;
    localparam logic [OPW-1:0] ALU_XOR  = 4'h4;
    localparam logic [OPW-1:0] ALU_NOR  = 4'h5;
    localparam logic [OPW-1:0] ALU_SLL  = 4'h6;
    localparam logic [OPW-1:0] ALU_SRL  = 4'h7;
    localparam logic [OPW-1:0] ALU_SRA  = 4'h8;
    localparam logic [OPW-1:0] ALU_SLT  = 4'h9;
    localparam logic [OPW-1:0] ALU_SLTU = 4'hA;
    localparam logic [OPW-1:0] ALU_LUI  = 4'hB;
    localparam logic [OPW-1:0] ALU_PASB = 4'hC;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      shamt;

    // Link register is reserved for a future JAL; nothing consumes it yet.
    logic unused_link;
    assign unused_link = ^LINK_REG;

    assign pc = pc_q;
    assign eq = (ra_data == rb_data);

    // Control decode: one select pattern per opcode class
    always_comb begin
        alu_op = ALU_ADD;
        m1     = 1'b0;
        m2     = 1'b0;
        m3     = 1'b0;
        m4     = 1'b0;
        m5     = 1'b0;
        m6     = 1'b0;
        m7     = 1'b0;
        wr_en  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
                m4    = 1'b1;
                m5    = 1'b1;
                m7    = 1'b1;
                wr_en = 1'b1;
                case (opcode)
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    OP_XOR:  alu_op = ALU_XOR;
                    OP_SLL:  alu_op = ALU_SLL;
                    OP_SRL:  alu_op = ALU_SRL;
                    OP_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                m5    = 1'b1;
                m6    = 1'b1;
                m7    = 1'b1;
                wr_en = 1'b1;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_MOV: wr_en = 1'b1;
            OP_BEQ: m2 = eq;
            OP_JR:  m1 = 1'b1;
            OP_BNE: m2 = ~eq;
            default: ;
        endcase
    end

    assign alu_b = m6 ? imm_ext : rb_data;
    assign shamt = alu_b[4:0];

    // ALU: codes D-F produce zero; arithmetic wraps mod 2^32
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = ra_data + alu_b;
            ALU_SUB:  alu_out = ra_data - alu_b;
            ALU_AND:  alu_out = ra_data & alu_b;
            ALU_OR:   alu_out = ra_data | alu_b;
            ALU_XOR:  alu_out = ra_data ^ alu_b;
            ALU_NOR:  alu_out = ~(ra_data | alu_b);
            ALU_SLL:  alu_out = ra_data << shamt;
            ALU_SRL:  alu_out = ra_data >> shamt;
            ALU_SRA:  alu_out = XLEN'($signed(ra_data) >>> shamt);
            ALU_SLT:  alu_out = ($signed(ra_data) < $signed(alu_b)) ? XLEN'(1) : '0;
            ALU_SLTU: alu_out = (ra_data < alu_b) ? XLEN'(1) : '0;
            ALU_LUI:  alu_out = alu_b << 16;
            ALU_PASB: alu_out = alu_b;
            default:  alu_out = '0;
        endcase
    end

    // Next PC: jump-register, or sequential/branch byte offset
    always_comb begin
        pc_inc = m2 ? imm_ext : XLEN'(4);
        pc_d   = m1 ? ra_data : pc_q + pc_inc;
    end

    // PC register, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed cases plus randomized
// instructions checked each cycle against an instruction-level model.
module tb_cpu_exec_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        eq;
    logic        m1, m2, m3, m4, m5, m6, m7;
    logic        wr_en;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_pc;

    cpu_exec_ctrl #(.RESET_PC(32'h0), .LINK_REG(4'hF)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .ra_data(ra_data), .rb_data(rb_data), .imm_ext(imm_ext),
        .pc(pc), .alu_op(alu_op), .alu_out(alu_out), .eq(eq),
        .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5), .m6(m6), .m7(m7),
        .wr_en(wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result each instruction leaves on the ALU output
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: return a + imm;
            4'h9: return a & imm;
            4'hA: return a | imm;
            4'hB: return {imm[15:0], 16'h0};
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] m_aluop(input logic [3:0] op);
        case (op)
            4'h5: return 4'h6;
            4'h6: return 4'h7;
            4'h7: return 4'h9;
            4'h9: return 4'h2;
            4'hA: return 4'h3;
            4'hB: return 4'hB;
            default: return (op < 4'h5) ? op : 4'h0;
        endcase
    endfunction

    // {m1,m3,m4,m5,m6,m7,wr_en} per instruction class
    function automatic logic [6:0] m_sel(input logic [3:0] op);
        if (op <= 4'h7) return 7'b0011011;
        if (op <= 4'hB) return 7'b0001111;
        if (op == 4'hC) return 7'b0000001;
        if (op == 4'hE) return 7'b1000000;
        return 7'b0000000;
    endfunction

    function automatic logic m_branch(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op == 4'hD) return a == b;
        if (op == 4'hF) return a != b;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_next_pc(input logic [31:0] cur, input logic [3:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] imm);
        if (op == 4'hE) return a;
        if (m_branch(op, a, b)) return cur + imm;
        return cur + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model PC tracks the instruction stream and the asynchronous clear
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_pc <= 32'h0;
        else      exp_pc <= m_next_pc(exp_pc, opcode, ra_data, rb_data, imm_ext);
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [6:0] s;
        s = m_sel(opcode);
        chk("cyc_pc",      pc,      exp_pc);
        chk("cyc_alu_out", alu_out, m_alu(opcode, ra_data, rb_data, imm_ext));
        chk("cyc_alu_op",  32'(alu_op), 32'(m_aluop(opcode)));
        chk("cyc_eq",      32'(eq), 32'(ra_data == rb_data));
        chk("cyc_m2",      32'(m2), 32'(m_branch(opcode, ra_data, rb_data)));
        chk("cyc_sel",     32'({m1, m3, m4, m5, m6, m7, wr_en}), 32'(s));
    end

    task automatic set_in(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm);
        opcode  = op;
        ra_data = a;
        rb_data = b;
        imm_ext = imm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(4'h0, 32'd5, 32'd7, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_pc", pc, 32'h0);
        rst = 1'b1;
        #1;
        chk("add_out", alu_out, 32'd12);
        chk("add_wr_m7", 32'({wr_en, m7}), 32'b11);
        tick();
        chk("first_pc", pc, 32'd4);

        set_in(4'h1, 32'd0, 32'd1, 32'd0);
        chk("sub_wrap", alu_out, 32'hFFFF_FFFF);
        set_in(4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0);
        chk("slt_neg", alu_out, 32'd1);
        chk("slt_op", 32'(alu_op), 32'h9);
        set_in(4'h8, 32'd1, 32'd0, 32'hFFFF_FFFF);
        chk("addi_out", alu_out, 32'd0);
        chk("addi_m6", 32'(m6), 32'd1);
        set_in(4'hB, 32'd0, 32'd0, 32'h0000_1234);
        chk("lui_out", alu_out, 32'h1234_0000);

        // BEQ taken from pc=16
        set_in(4'hE, 32'd16, 32'd0, 32'd0);
        tick();
        chk("jr16", pc, 32'd16);
        set_in(4'hD, 32'd9, 32'd9, 32'hFFFF_FFF8);
        chk("beq_eq_m2", 32'({eq, m2}), 32'b11);
        tick();
        chk("beq_taken", pc, 32'd8);
        // BEQ not taken from pc=16
        set_in(4'hE, 32'd16, 32'd0, 32'd0);
        tick();
        set_in(4'hD, 32'd9, 32'd3, 32'hFFFF_FFF8);
        tick();
        chk("beq_not", pc, 32'd20);
        // BNE taken from pc=20
        set_in(4'hF, 32'd9, 32'd3, 32'hFFFF_FFF8);
        chk("bne_m2", 32'(m2), 32'd1);
        tick();
        chk("bne_taken", pc, 32'd12);
        set_in(4'hF, 32'd9, 32'd9, 32'hFFFF_FFF8);
        tick();
        chk("bne_not", pc, 32'd16);

        set_in(4'hE, 32'h100, 32'd0, 32'd0);
        chk("jr_sel", 32'({m1, wr_en}), 32'b10);
        tick();
        chk("jr_pc", pc, 32'h100);
        set_in(4'hC, 32'd3, 32'd4, 32'd0);
        chk("mov_sel", 32'({wr_en, m5, m7}), 32'b100);

        // Unaligned JR target, then wrap past the top of memory
        set_in(4'hE, 32'h0000_0103, 32'd0, 32'd0);
        tick();
        chk("jr_unaligned", pc, 32'h0000_0103);
        set_in(4'hE, 32'hFFFF_FFFC, 32'd0, 32'd0);
        tick();
        set_in(4'h0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("pc_wrap", pc, 32'h0);

        // Mid-cycle reset clears at once and holds across edges
        set_in(4'hE, 32'h40, 32'd0, 32'd0);
        tick();
        chk("pre_reset", pc, 32'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_now", pc, 32'h0);
        tick();
        tick();
        chk("midreset_hold", pc, 32'h0);
        rst = 1'b1;
        tick();
        chk("post_reset", pc, 32'h40);

        // Randomized instruction stream
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b, imm;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h0000_001F;
            set_in(4'($urandom_range(0, 15)), a, b, imm);
            if ($urandom_range(0, 99) == 0) rst = 1'b0;
            else                            rst = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
